mul_div_unit: RTL and testbench



---
 rtl/mul_div_unit.sv | 114 +++++++++++
 tb/tb_mul_div_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply (shift-add) and divide (restoring) unit.
// One operand bit per cycle; results held in hi/lo until the next op completes.
module mul_div_unit #(
   parameter int WIDTH = 16,
   parameter int CW    = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t state, state_n;

   logic [CW-1:0]    cnt;
   logic             opr;
   logic             dz_p;
   logic [WIDTH-1:0] breg;
   logic [WIDTH-1:0] acc, acc_n;
   logic [WIDTH-1:0] q, q_n;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shf;
   logic             accept;
   logic             last;

   assign accept = start && (state != S_BUSY);
   assign last   = (state == S_BUSY) &&
                   (dz_p || (cnt == CW'(WIDTH - 1)));
   assign busy   = (state == S_BUSY);
   assign done   = (state == S_DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE:  if (start) state_n = S_BUSY;
         S_BUSY:  if (last) state_n = S_DONE;
         S_DONE:  state_n = start ? S_BUSY : S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // acc holds the running upper product / partial remainder
   always_comb begin
      sum   = {1'b0, acc} + {1'b0, (q[0] ? breg : '0)};
      shf   = {acc, q[WIDTH-1]};
      acc_n = acc;
      q_n   = q;
      if (!opr) begin
         acc_n = sum[WIDTH:1];
         q_n   = {sum[0], q[WIDTH-1:1]};
      end else if (shf >= {1'b0, breg}) begin
         acc_n = WIDTH'(shf - {1'b0, breg});
         q_n   = {q[WIDTH-2:0], 1'b1};
      end else begin
         acc_n = shf[WIDTH-1:0];
         q_n   = {q[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt      <= '0;
         opr      <= 1'b0;
         dz_p     <= 1'b0;
         breg     <= '0;
         acc      <= '0;
         q        <= '0;
         hi       <= '0;
         lo       <= '0;
         div_zero <= 1'b0;
      end else if (accept) begin
         cnt      <= '0;
         opr      <= op;
         dz_p     <= op && (b == '0);
         breg     <= b;
         acc      <= '0;
         q        <= a;
         div_zero <= 1'b0;
      end else if (state == S_BUSY) begin
         if (dz_p) begin
            hi       <= q;
            lo       <= '1;
            div_zero <= 1'b1;
         end else begin
            acc <= acc_n;
            q   <= q_n;
            cnt <= cnt + 1'b1;
            if (last) begin
               hi <= acc_n;
               lo <= q_n;
            end
         end
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed vectors, monitor checks on done.
// Expected results and completion cycles are queued at issue time.
module tb_mul_div_unit;

   typedef struct {
      logic [15:0] hi;
      logic [15:0] lo;
      logic        dz;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        busy, done, div_zero;
   logic [15:0] hi, lo;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   fails = 0;

   mul_div_unit #(.WIDTH(16), .CW(5)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .a(a), .b(b), .busy(busy), .done(done),
      .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && done) begin
         if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_done at cycle %0d", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("hi", int'(hi), int'(e.hi));
            chk("lo", int'(lo), int'(e.lo));
            chk("div_zero", int'(div_zero), int'(e.dz));
            chk("busy_in_done", int'(busy), 0);
         end
      end
   end

   // Drives start for one cycle; caller must be positioned at a negedge.
   task automatic issue(input logic o, input logic [15:0] x,
                        input logic [15:0] y, input logic [15:0] eh,
                        input logic [15:0] el, input logic ed,
                        input int lat, input bit expect_done);
      exp_t e;
      start = 1'b1;
      op = o;
      a = x;
      b = y;
      if (expect_done) begin
         e.hi = eh;
         e.lo = el;
         e.dz = ed;
         e.cyc = cyc + 1 + lat;
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
      a = 16'h5A5A;
      b = 16'hA5A5;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 40; i++) begin
         if (done) return;
         @(negedge clk);
      end
      checks++;
      fails++;
      $display("FAIL wait_done timeout at cycle %0d", cyc);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_hi"}, int'(hi), 0);
      chk({tag, "_lo"}, int'(lo), 0);
      chk({tag, "_dz"}, int'(div_zero), 0);
   endtask

   initial begin
      #50;
      chk_zero("reset");
      #50;
      reset = 1'b0;
      @(negedge clk);

      issue(1'b0, 16'd100, 16'd101, 16'h0000, 16'h2774, 1'b0, 16, 1'b1);
      wait_done();
      issue(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 16, 1'b1);
      wait_done();
      issue(1'b1, 16'd100, 16'd7, 16'd2, 16'd14, 1'b0, 16, 1'b1);
      wait_done();
      issue(1'b1, 16'd100, 16'd0, 16'd100, 16'hFFFF, 1'b1, 1, 1'b1);
      wait_done();
      @(negedge clk);
      chk("dz_hold", int'(div_zero), 1);
      chk("hi_hold", int'(hi), 100);
      issue(1'b0, 16'd3, 16'd4, 16'd0, 16'd12, 1'b0, 16, 1'b1);
      chk("dz_cleared", int'(div_zero), 0);
      chk("lo_hold_busy", int'(lo), 16'hFFFF);
      wait_done();
      @(negedge clk);

      issue(1'b0, 16'd5, 16'd6, 16'd0, 16'd30, 1'b0, 16, 1'b1);
      repeat (3) @(negedge clk);
      issue(1'b0, 16'd9, 16'd9, 16'd0, 16'd0, 1'b0, 16, 1'b0);
      wait_done();
      @(negedge clk);

      issue(1'b0, 16'd5, 16'd6, 16'd0, 16'd0, 1'b0, 16, 1'b0);
      repeat (6) @(negedge clk);
      reset = 1'b1;
      #1;
      chk_zero("abort");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      chk("no_done_after_abort", int'(lo), 0);

      issue(1'b1, 16'd100, 16'd5, 16'd0, 16'd20, 1'b0, 16, 1'b1);
      wait_done();
      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
